fu_jump_pipe: RTL and testbench

//  Pipelined branch/jump functional unit. Accepts one JAL/JALR/branch op per cycle,

---
 rtl/fu_jump_pipe.sv | 134 +++++++++++++
 tb/tb_fu_jump_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fu_jump_pipe.sv
// Pipelined branch/jump unit: resolves condition, target and link address, then carries them
// through LATENCY registers. Define PRED_CHECK_EN to add prediction inputs and a mispredict output.
module fu_jump_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  output logic             ready,
  input  logic             flush,
  input  logic             stall,
  input  logic             JALR,
  input  logic [3:0]       cmp_ctrl,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  PC,
  input  logic [TAG_W-1:0] tag_in,
`ifdef PRED_CHECK_EN
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             mispredict,
`endif
  output logic             finish,
  output logic             is_jump,
  output logic [XLEN-1:0]  PC_jump,
  output logic [XLEN-1:0]  PC_wb,
  output logic [TAG_W-1:0] tag_out,
  output logic             misalign
);

  logic             w_advance;
  logic             w_taken;
  logic             w_misalign;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_link;

  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] r_jump;
  logic [LATENCY-1:0] r_misalign;
  logic [XLEN-1:0]    r_pc_jump [LATENCY];
  logic [XLEN-1:0]    r_pc_wb   [LATENCY];
  logic [TAG_W-1:0]   r_tag     [LATENCY];
`ifdef PRED_CHECK_EN
  logic [LATENCY-1:0] r_pred_taken;
  logic [XLEN-1:0]    r_pred_target [LATENCY];
`endif

  // The whole pipe moves together; a held result at the tail freezes every stage.
  assign w_advance = ~r_valid[LATENCY-1] | ~stall;
  assign ready     = w_advance & ~rst;

  always_comb begin
    w_taken = 1'b0;
    unique casez (cmp_ctrl)
      4'b000?: w_taken = 1'b0;
      4'b001?: w_taken = (rs1_data == rs2_data);
      4'b010?: w_taken = (rs1_data != rs2_data);
      4'b011?: w_taken = ($signed(rs1_data) < $signed(rs2_data));
      4'b100?: w_taken = ($signed(rs1_data) >= $signed(rs2_data));
      4'b101?: w_taken = (rs1_data < rs2_data);
      4'b110?: w_taken = (rs1_data >= rs2_data);
      4'b111?: w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_target   = JALR ? ((rs1_data + imm) & {{(XLEN-1){1'b1}}, 1'b0}) : (PC + imm);
  assign w_link     = PC + XLEN'(4);
  assign w_misalign = w_taken & (w_target[1:0] != 2'b00);

  // Stage data loads only behind a valid op so the tail keeps the last result across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_jump     <= '0;
      r_misalign <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pc_jump[i] <= '0;
        r_pc_wb[i]   <= '0;
        r_tag[i]     <= '0;
      end
`ifdef PRED_CHECK_EN
      r_pred_taken <= '0;
      for (int i = 0; i < LATENCY; i++) r_pred_target[i] <= '0;
`endif
    end else if (flush) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid[0] <= EN;
      if (EN) begin
        r_jump[0]     <= w_taken;
        r_misalign[0] <= w_misalign;
        r_pc_jump[0]  <= w_target;
        r_pc_wb[0]    <= w_link;
        r_tag[0]      <= tag_in;
`ifdef PRED_CHECK_EN
        r_pred_taken[0]  <= pred_taken;
        r_pred_target[0] <= pred_target;
`endif
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
        if (r_valid[i-1]) begin
          r_jump[i]     <= r_jump[i-1];
          r_misalign[i] <= r_misalign[i-1];
          r_pc_jump[i]  <= r_pc_jump[i-1];
          r_pc_wb[i]    <= r_pc_wb[i-1];
          r_tag[i]      <= r_tag[i-1];
`ifdef PRED_CHECK_EN
          r_pred_taken[i]  <= r_pred_taken[i-1];
          r_pred_target[i] <= r_pred_target[i-1];
`endif
        end
      end
    end
  end

  assign finish   = r_valid[LATENCY-1];
  assign is_jump  = finish & r_jump[LATENCY-1];
  assign misalign = finish & r_misalign[LATENCY-1];
  assign PC_jump  = r_pc_jump[LATENCY-1];
  assign PC_wb    = r_pc_wb[LATENCY-1];
  assign tag_out  = r_tag[LATENCY-1];

`ifdef PRED_CHECK_EN
  assign mispredict = finish & ((r_jump[LATENCY-1] != r_pred_taken[LATENCY-1]) |
                                (r_jump[LATENCY-1] &
                                 (r_pred_target[LATENCY-1] != r_pc_jump[LATENCY-1])));
`endif

endmodule

// File: tb/tb_fu_jump_pipe.sv
// Scoreboard bench for fu_jump_pipe: issued ops are modelled as aged queue entries, and a
// negedge monitor compares the DUT outputs with the queue head every cycle.
module tb_fu_jump_pipe;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst, EN, flush, stall, JALR;
  logic        ready, finish, is_jump, misalign;
  logic [3:0]  cmp_ctrl, tag_in, tag_out;
  logic [31:0] rs1_data, rs2_data, imm, PC, PC_jump, PC_wb;
  logic        pred_taken;
  logic [31:0] pred_target;
`ifdef PRED_CHECK_EN
  logic        mispredict;
`endif

  fu_jump_pipe #(.XLEN(32), .LATENCY(LAT), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .EN(EN), .ready(ready), .flush(flush), .stall(stall),
    .JALR(JALR), .cmp_ctrl(cmp_ctrl), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .PC(PC), .tag_in(tag_in),
`ifdef PRED_CHECK_EN
    .pred_taken(pred_taken), .pred_target(pred_target), .mispredict(mispredict),
`endif
    .finish(finish), .is_jump(is_jump), .PC_jump(PC_jump), .PC_wb(PC_wb),
    .tag_out(tag_out), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jmp;
    logic        mis;
    logic [31:0] tgt;
    logic [31:0] wb;
    logic [3:0]  tag;
    logic        pt;
    logic [31:0] ptg;
    int          age;
  } op_t;

  op_t         q[$];
  logic [31:0] last_tgt = 0, last_wb = 0;
  logic [3:0]  last_tag = 0;
  bit          started = 0;
  int          checks = 0, failures = 0;

  function automatic op_t model(input logic jalr, input logic [3:0] cc, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] im,
                                input logic [31:0] pc, input logic [3:0] tg,
                                input logic pt, input logic [31:0] ptg);
    op_t o;
    int  sa, sb;
    sa = a;
    sb = b;
    case (cc[3:1])
      3'd0: o.jmp = 0;
      3'd1: o.jmp = (a == b);
      3'd2: o.jmp = (a != b);
      3'd3: o.jmp = (sa < sb);
      3'd4: o.jmp = (sa >= sb);
      3'd5: o.jmp = (a < b);
      3'd6: o.jmp = (a >= b);
      default: o.jmp = 1;
    endcase
    o.tgt = jalr ? ((a + im) & 32'hFFFF_FFFE) : (pc + im);
    o.wb  = pc + 32'd4;
    o.mis = o.jmp && (o.tgt % 4 != 0);
    o.tag = tg;
    o.pt  = pt;
    o.ptg = ptg;
    o.age = 0;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: ages count pipe advances; an op is at the output when age == LAT-1.
  always @(posedge clk) begin
    bit fin, adv;
    fin = (q.size() > 0) && (q[0].age == LAT - 1);
    adv = !fin || !stall;
    if (rst) begin
      q.delete();
      last_tgt = 0;
      last_wb  = 0;
      last_tag = 0;
    end else if (flush) begin
      q.delete();
    end else if (adv) begin
      if (fin) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (EN) q.push_back(model(JALR, cmp_ctrl, rs1_data, rs2_data, imm, PC, tag_in,
                                pred_taken, pred_target));
    end
    if (q.size() > 0 && q[0].age == LAT - 1) begin
      last_tgt = q[0].tgt;
      last_wb  = q[0].wb;
      last_tag = q[0].tag;
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      bit fin_e;
      fin_e = (q.size() > 0) && (q[0].age == LAT - 1);
      chk("finish", {31'd0, finish}, {31'd0, fin_e});
      chk("ready", {31'd0, ready}, {31'd0, (!fin_e || !stall) && !rst});
      chk("is_jump", {31'd0, is_jump}, {31'd0, fin_e && q[0].jmp});
      chk("misalign", {31'd0, misalign}, {31'd0, fin_e && q[0].mis});
      chk("PC_jump", PC_jump, last_tgt);
      chk("PC_wb", PC_wb, last_wb);
      chk("tag_out", {28'd0, tag_out}, {28'd0, last_tag});
`ifdef PRED_CHECK_EN
      chk("mispredict", {31'd0, mispredict},
          {31'd0, fin_e && ((q[0].jmp != q[0].pt) || (q[0].jmp && q[0].ptg != q[0].tgt))});
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic jalr, input logic [3:0] cc, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] im, input logic [31:0] pc,
                    input logic [3:0] tg);
    EN = 1; JALR = jalr; cmp_ctrl = cc; rs1_data = a; rs2_data = b; imm = im; PC = pc;
    tag_in = tg;
  endtask

  initial begin
    rst = 1; EN = 0; flush = 0; stall = 0; JALR = 0; cmp_ctrl = 0; rs1_data = 0;
    rs2_data = 0; imm = 0; PC = 0; tag_in = 0; pred_taken = 0; pred_target = 0;
    repeat (3) cyc();
    rst = 0;
    // BEQ taken, JALR bit-0 clear, JAL misaligned, signed vs unsigned, PC wrap
    op(0, 4'b0010, 5, 5, 32'h20, 32'h100, 4'd1);            cyc();
    op(1, 4'b1110, 32'h1001, 0, 32'h4, 32'h40, 4'd2);       cyc();
    op(0, 4'b1111, 0, 0, 32'h2, 32'h0, 4'd3);               cyc();
    op(0, 4'b0110, 32'hFFFF_FFFF, 1, 32'h8, 32'h80, 4'd4);  cyc();
    op(0, 4'b1010, 32'hFFFF_FFFF, 1, 32'h8, 32'h80, 4'd5);  cyc();
    op(0, 4'b1110, 0, 0, 32'h8, 32'hFFFF_FFFC, 4'd6);       cyc();
    EN = 0; repeat (4) cyc();
    // Back-to-back with a three-cycle stall once the first result appears
    op(0, 4'b1110, 0, 0, 32'h10, 32'h300, 4'd1);            cyc();
    op(0, 4'b1110, 0, 0, 32'h10, 32'h304, 4'd2);            cyc();
    op(0, 4'b1110, 0, 0, 32'h10, 32'h308, 4'd3);
    stall = 1; repeat (3) cyc();
    stall = 0; cyc();
    EN = 0; repeat (4) cyc();
    // Flush with a same-cycle issue, then reset with ops in flight
    op(0, 4'b0100, 1, 2, 32'h4, 32'h400, 4'd7);             cyc();
    op(0, 4'b0100, 1, 2, 32'h4, 32'h404, 4'd8);             flush = 1; cyc();
    flush = 0; EN = 0; repeat (3) cyc();
    op(0, 4'b1110, 0, 0, 32'h4, 32'h500, 4'd9);             cyc();
    op(0, 4'b1110, 0, 0, 32'h4, 32'h504, 4'd10);            rst = 1; cyc();
    rst = 0; EN = 0; repeat (3) cyc();
`ifdef PRED_CHECK_EN
    op(0, 4'b0100, 1, 2, 32'h10, 32'h200, 4'd11); pred_taken = 1; pred_target = 32'h214; cyc();
    op(0, 4'b0100, 1, 2, 32'h10, 32'h200, 4'd12); pred_taken = 1; pred_target = 32'h210; cyc();
    EN = 0; pred_taken = 0; repeat (3) cyc();
`endif
    // Randomized traffic with stalls, flushes and occasional resets
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, b, im, pc;
      logic        jl;
      logic [3:0]  cc;
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
      im = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom();
      pc = $urandom();
      jl = 1'($urandom_range(0, 1));
      cc = 4'($urandom_range(0, 15));
      op(jl, cc, a, b, im, pc, 4'($urandom_range(0, 15)));
      EN          = ($urandom_range(0, 3) != 0);
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 24) == 0);
      rst         = ($urandom_range(0, 79) == 0);
      pred_taken  = 1'($urandom_range(0, 1));
      pred_target = ($urandom_range(0, 1) == 0) ? (jl ? ((a + im) & 32'hFFFF_FFFE) : pc + im)
                                                : $urandom();
      cyc();
    end
    EN = 0; stall = 0; flush = 0; rst = 0;
    begin
      int budget;
      budget = 20;
      while (q.size() > 0 && budget > 0) begin
        cyc();
        budget--;
      end
      chk("drain_done", {31'd0, q.size() == 0}, 32'd1);
    end
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
